// File: rtl/uart_pattern_pkg.sv
// Shared types and helpers for the UART pattern detector.
package uart_pattern_pkg;

  localparam int unsigned DataWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  // Clock cycles per serial bit.
  function automatic int unsigned calc_bit_ticks(input int unsigned clk_hz,
                                                 input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Clock cycles from the start edge to the middle of the start bit.
  function automatic int unsigned calc_half_ticks(input int unsigned clk_hz,
                                                  input int unsigned baud);
    return (clk_hz / baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// 8N1 receive front end: synchronizer, start detect, bit timing and stop check.
module uart_rx_sampler
  import uart_pattern_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115_200
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rx_i,
  output logic sample_valid_o,
  output logic sample_bit_o,
  output logic bit_strobe_o,
  output logic frame_done_o,
  output logic framing_error_o
);

  localparam int unsigned BitTicks  = calc_bit_ticks(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned HalfTicks = calc_half_ticks(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned TickW     = $clog2(BitTicks);
  localparam int unsigned IdxW      = $clog2(DataWidth);

  localparam logic [TickW-1:0] BitLoad  = TickW'(BitTicks - 1);
  localparam logic [TickW-1:0] HalfLoad = TickW'(HalfTicks - 1);
  localparam logic [IdxW-1:0]  LastIdx  = IdxW'(DataWidth - 1);

  rx_state_e        state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic             strobe_q, strobe_d;
  logic             done_q, done_d;
  logic             fe_q, fe_d;
  logic             fall;

  // Falling edge only after the line has been seen high, so a stuck-low line never re-arms.
  assign fall         = rx_prev_q & ~rx_sync_q;
  assign sample_bit_o = rx_sync_q;

  // Two-flop synchronizer plus the previous-value flop for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // FSM, tick counter, bit index and registered status pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      idx_q    <= '0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
      fe_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
      fe_q     <= fe_d;
    end
  end

  // Next-state logic; each sample point is reached when the tick counter hits zero.
  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    idx_d          = idx_q;
    fe_d           = fe_q;
    strobe_d       = 1'b0;
    done_d         = 1'b0;
    sample_valid_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (fall) begin
          state_d = StStart;
          tick_d  = HalfLoad;
        end
      end
      StStart: begin
        if (tick_q == '0) begin
          if (rx_sync_q) begin
            state_d = StIdle;  // glitch, not a real start bit
          end else begin
            state_d = StData;
            tick_d  = BitLoad;
            idx_d   = '0;
          end
        end else begin
          tick_d = tick_q - TickW'(1);
        end
      end
      StData: begin
        if (tick_q == '0) begin
          sample_valid_o = 1'b1;
          strobe_d       = 1'b1;
          tick_d         = BitLoad;
          if (idx_q == LastIdx) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end else begin
          tick_d = tick_q - TickW'(1);
        end
      end
      StStop: begin
        if (tick_q == '0) begin
          done_d  = 1'b1;
          fe_d    = ~rx_sync_q;
          state_d = StIdle;
        end else begin
          tick_d = tick_q - TickW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bit_strobe_o    = strobe_q;
  assign frame_done_o    = done_q;
  assign framing_error_o = fe_q;

endmodule

// File: rtl/uart_pattern_top.sv
// UART receiver feeding a persistent sliding bit window and a 4-bit pattern matcher.
module uart_pattern_top
  import uart_pattern_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ   = 50_000_000,
  parameter int unsigned BAUD_RATE     = 115_200,
  parameter logic [3:0]  ID_LAST_DIGIT = 4'd7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic                 match_o,
  output logic                 framing_error_o,
  output logic [DataWidth-1:0] shift_window_o,
  output logic                 frame_done_o,
  output logic                 bit_strobe_o
);

  logic                 sample_valid;
  logic                 sample_bit;
  logic [DataWidth-1:0] window_q, window_d;
  logic [2:0]           cnt_q, cnt_d;
  logic                 match_q, match_d;

  uart_rx_sampler #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD_RATE)
  ) u_sampler (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .rx_i           (rx_i),
    .sample_valid_o (sample_valid),
    .sample_bit_o   (sample_bit),
    .bit_strobe_o   (bit_strobe_o),
    .frame_done_o   (frame_done_o),
    .framing_error_o(framing_error_o)
  );

  // Window, saturating bit count and match flag; cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      window_q <= '0;
      cnt_q    <= '0;
      match_q  <= 1'b0;
    end else begin
      window_q <= window_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
    end
  end

  // Window/count update on each sample; match judged on the window visible during bit_strobe.
  always_comb begin
    window_d = window_q;
    cnt_d    = cnt_q;
    if (sample_valid) begin
      window_d = {window_q[DataWidth-2:0], sample_bit};
      if (cnt_q < 3'd4) begin
        cnt_d = cnt_q + 3'd1;
      end
    end
    match_d = bit_strobe_o && (window_q[3:0] == ID_LAST_DIGIT) && (cnt_q >= 3'd4);
  end

  assign shift_window_o = window_q;
  assign match_o        = match_q;

endmodule

// File: tb/tb_uart_pattern_top.sv
// Self-checking bench for uart_pattern_top with a frame-level reference model.
module tb_uart_pattern_top;

  localparam int unsigned ClkHz   = 600_000;
  localparam int unsigned Baud    = 100_000;
  localparam int unsigned BitClks = ClkHz / Baud;
  localparam logic [3:0]  Id      = 4'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       match, framing_error, frame_done, bit_strobe;
  logic [7:0] shift_window;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_pattern_top #(
    .CLK_FREQ_HZ  (ClkHz),
    .BAUD_RATE    (Baud),
    .ID_LAST_DIGIT(Id)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_i           (rx),
    .match_o        (match),
    .framing_error_o(framing_error),
    .shift_window_o (shift_window),
    .frame_done_o   (frame_done),
    .bit_strobe_o   (bit_strobe)
  );

  // Observed events since the last reset.
  int         mon_strobes;
  logic [7:0] mon_win_q[$];
  int         mon_match_q[$];
  logic       mon_fd_q[$];
  logic       mon_prev_strobe;
  logic       mon_prev_match;
  int         mon_bad_match;

  always @(negedge clk) begin
    if (rst) begin
      mon_win_q.delete();
      mon_match_q.delete();
      mon_fd_q.delete();
      mon_strobes     <= 0;
      mon_prev_strobe <= 1'b0;
      mon_prev_match  <= 1'b0;
      mon_bad_match   <= 0;
    end else begin
      if (bit_strobe) begin
        mon_win_q.push_back(shift_window);
        mon_strobes <= mon_strobes + 1;
      end
      if (match) begin
        mon_match_q.push_back(mon_strobes - 1);
        if (mon_prev_match || !mon_prev_strobe) mon_bad_match <= mon_bad_match + 1;
      end
      if (frame_done) mon_fd_q.push_back(framing_error);
      mon_prev_strobe <= bit_strobe;
      mon_prev_match  <= match;
    end
  end

  // Reference model: the bit stream since reset as a number, plus expected events.
  int         mdl_bits;
  logic [7:0] mdl_win;
  logic [7:0] exp_win_q[$];
  int         exp_match_q[$];
  logic       exp_fd_q[$];

  task automatic model_clear();
    mdl_bits = 0;
    mdl_win  = 8'h00;
    exp_win_q.delete();
    exp_match_q.delete();
    exp_fd_q.delete();
  endtask

  task automatic model_frame(input logic [7:0] data, input logic stop);
    for (int i = 0; i < 8; i++) begin
      int b;
      b       = (int'(data) >> i) % 2;
      mdl_win = 8'((int'(mdl_win) * 2 + b) % 256);
      mdl_bits++;
      exp_win_q.push_back(mdl_win);
      if (mdl_bits >= 4 && (int'(mdl_win) % 16) == int'(Id)) exp_match_q.push_back(mdl_bits - 1);
    end
    exp_fd_q.push_back(!stop);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx  = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    rx = 1'b0;
    repeat (BitClks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BitClks) @(negedge clk);
    end
    rx = stop;
    repeat (BitClks) @(negedge clk);
    model_frame(data, stop);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    model_clear();
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (match !== 1'b0) begin n_errors++; $display("FAIL reset match got %b want 0", match); end
    if (framing_error !== 1'b0) begin
      n_errors++; $display("FAIL reset framing_error got %b want 0", framing_error);
    end
    if (shift_window !== 8'h00) begin
      n_errors++; $display("FAIL reset shift_window got %h want 00", shift_window);
    end
    if (frame_done !== 1'b0) begin n_errors++; $display("FAIL reset frame_done got %b want 0", frame_done); end
    if (bit_strobe !== 1'b0) begin n_errors++; $display("FAIL reset bit_strobe got %b want 0", bit_strobe); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_known_frames();
    do_reset();
    send_frame(8'hCE, 1'b1);
    send_frame(8'hEE, 1'b1);
    send_frame(8'hF0, 1'b1);
    repeat (4) @(negedge clk);
    n_checks += 4;
    if (mon_win_q.size() != 24) begin
      n_errors++; $display("FAIL known strobes got %0d want 24", mon_win_q.size());
    end
    if (mon_match_q.size() != 4) begin
      n_errors++; $display("FAIL known matches got %0d want 4", mon_match_q.size());
    end
    if (mon_fd_q.size() != exp_fd_q.size()) begin
      n_errors++; $display("FAIL known frame_done got %0d want %0d", mon_fd_q.size(), exp_fd_q.size());
    end
    if (mon_bad_match != 0) begin n_errors++; $display("FAIL known bad_match got %0d want 0", mon_bad_match); end
    for (int i = 0; i < exp_win_q.size() && i < mon_win_q.size(); i++) begin
      n_checks++;
      if (mon_win_q[i] !== exp_win_q[i]) begin
        n_errors++; $display("FAIL known window[%0d] got %h want %h", i, mon_win_q[i], exp_win_q[i]);
      end
    end
    for (int i = 0; i < exp_match_q.size() && i < mon_match_q.size(); i++) begin
      n_checks++;
      if (mon_match_q[i] != exp_match_q[i]) begin
        n_errors++; $display("FAIL known match_idx[%0d] got %0d want %0d", i, mon_match_q[i], exp_match_q[i]);
      end
    end
    for (int i = 0; i < exp_fd_q.size() && i < mon_fd_q.size(); i++) begin
      n_checks++;
      if (mon_fd_q[i] !== exp_fd_q[i]) begin
        n_errors++; $display("FAIL known fe[%0d] got %b want %b", i, mon_fd_q[i], exp_fd_q[i]);
      end
    end
  endtask

  task automatic test_all_ones();
    do_reset();
    send_frame(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    n_checks += 5;
    if (mon_win_q.size() != 8) begin n_errors++; $display("FAIL ones strobes got %0d want 8", mon_win_q.size()); end
    if (shift_window !== 8'hFF) begin n_errors++; $display("FAIL ones window got %h want ff", shift_window); end
    if (mon_match_q.size() != 0) begin
      n_errors++; $display("FAIL ones matches got %0d want 0", mon_match_q.size());
    end
    if (mon_fd_q.size() != 1) begin n_errors++; $display("FAIL ones frame_done got %0d want 1", mon_fd_q.size()); end
    if (framing_error !== 1'b0) begin n_errors++; $display("FAIL ones fe got %b want 0", framing_error); end
  endtask

  task automatic test_bad_stop();
    do_reset();
    send_frame(8'hA5, 1'b0);
    repeat (40) @(negedge clk);  // line stays low
    n_checks += 4;
    if (mon_win_q.size() != 8) begin n_errors++; $display("FAIL badstop strobes got %0d want 8", mon_win_q.size()); end
    if (mon_fd_q.size() != 1) begin
      n_errors++; $display("FAIL badstop frame_done got %0d want 1", mon_fd_q.size());
    end else if (mon_fd_q[0] !== 1'b1) begin
      n_errors++; $display("FAIL badstop fe_at_done got %b want 1", mon_fd_q[0]);
    end
    if (framing_error !== 1'b1) begin n_errors++; $display("FAIL badstop fe_hold got %b want 1", framing_error); end
    if (mon_match_q.size() != exp_match_q.size()) begin
      n_errors++; $display("FAIL badstop matches got %0d want %0d", mon_match_q.size(), exp_match_q.size());
    end
    for (int i = 0; i < exp_win_q.size() && i < mon_win_q.size(); i++) begin
      n_checks++;
      if (mon_win_q[i] !== exp_win_q[i]) begin
        n_errors++; $display("FAIL badstop window[%0d] got %h want %h", i, mon_win_q[i], exp_win_q[i]);
      end
    end
    rx = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_glitch();
    do_reset();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    n_checks += 3;
    if (mon_win_q.size() != 0) begin n_errors++; $display("FAIL glitch strobes got %0d want 0", mon_win_q.size()); end
    if (mon_fd_q.size() != 0) begin n_errors++; $display("FAIL glitch frame_done got %0d want 0", mon_fd_q.size()); end
    if (mon_match_q.size() != 0) begin
      n_errors++; $display("FAIL glitch matches got %0d want 0", mon_match_q.size());
    end
    // Receiver must be back in idle and take a normal frame.
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (mon_win_q.size() != exp_win_q.size()) begin
      n_errors++; $display("FAIL glitch_after strobes got %0d want %0d", mon_win_q.size(), exp_win_q.size());
    end
    for (int i = 0; i < exp_win_q.size() && i < mon_win_q.size(); i++) begin
      n_checks++;
      if (mon_win_q[i] !== exp_win_q[i]) begin
        n_errors++; $display("FAIL glitch_after window[%0d] got %h want %h", i, mon_win_q[i], exp_win_q[i]);
      end
    end
  endtask

  task automatic test_first_bits();
    do_reset();
    send_frame(8'h07, 1'b1);  // bits 1,1,1,0: window 0x07 after only 3 bits
    send_frame(8'hE3, 1'b1);
    repeat (4) @(negedge clk);
    n_checks += 3;
    if (mon_win_q.size() < 3 || mon_win_q[2] !== 8'h07) begin
      n_errors++; $display("FAIL first window_after_3 got %h want 07", (mon_win_q.size() < 3) ? 8'hxx : mon_win_q[2]);
    end
    if (mon_match_q.size() != exp_match_q.size()) begin
      n_errors++; $display("FAIL first matches got %0d want %0d", mon_match_q.size(), exp_match_q.size());
    end
    if (mon_bad_match != 0) begin n_errors++; $display("FAIL first bad_match got %0d want 0", mon_bad_match); end
    for (int i = 0; i < mon_match_q.size(); i++) begin
      n_checks++;
      if (mon_match_q[i] < 3) begin
        n_errors++; $display("FAIL first early_match got idx %0d want >=3", mon_match_q[i]);
      end
    end
    for (int i = 0; i < exp_win_q.size() && i < mon_win_q.size(); i++) begin
      n_checks++;
      if (mon_win_q[i] !== exp_win_q[i]) begin
        n_errors++; $display("FAIL first window[%0d] got %h want %h", i, mon_win_q[i], exp_win_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] data;
    do_reset();
    send_frame(8'h11, 1'b0);  // leave framing_error set
    rx = 1'b1;
    repeat (BitClks) @(negedge clk);
    data = 8'hB5;
    rx = 1'b0;
    repeat (BitClks) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = data[i];
      repeat (BitClks) @(negedge clk);
    end
    rx = data[3];
    repeat (3) @(negedge clk);
    n_checks++;
    if (mon_strobes != 11) begin n_errors++; $display("FAIL midrst pre_strobes got %0d want 11", mon_strobes); end
    #2 rst = 1'b1;
    #1;
    n_checks += 5;
    if (match !== 1'b0) begin n_errors++; $display("FAIL midrst match got %b want 0", match); end
    if (framing_error !== 1'b0) begin n_errors++; $display("FAIL midrst fe got %b want 0", framing_error); end
    if (shift_window !== 8'h00) begin n_errors++; $display("FAIL midrst window got %h want 00", shift_window); end
    if (frame_done !== 1'b0) begin n_errors++; $display("FAIL midrst frame_done got %b want 0", frame_done); end
    if (bit_strobe !== 1'b0) begin n_errors++; $display("FAIL midrst bit_strobe got %b want 0", bit_strobe); end
    rx = 1'b1;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    n_checks += 2;
    if (mon_win_q.size() != 8) begin n_errors++; $display("FAIL midrst strobes got %0d want 8", mon_win_q.size()); end
    if (mon_fd_q.size() != 1 || mon_fd_q[0] !== 1'b0) begin
      n_errors++; $display("FAIL midrst frame_done count %0d want 1 with fe 0", mon_fd_q.size());
    end
    for (int i = 0; i < exp_win_q.size() && i < mon_win_q.size(); i++) begin
      n_checks++;
      if (mon_win_q[i] !== exp_win_q[i]) begin
        n_errors++; $display("FAIL midrst window[%0d] got %h want %h", i, mon_win_q[i], exp_win_q[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int f = 0; f < 12; f++) begin
      logic [7:0] data;
      logic       stop;
      data = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(data, stop);
      rx = 1'b1;
      repeat (BitClks) @(negedge clk);
    end
    n_checks += 4;
    if (mon_win_q.size() != exp_win_q.size()) begin
      n_errors++; $display("FAIL random strobes got %0d want %0d", mon_win_q.size(), exp_win_q.size());
    end
    if (mon_match_q.size() != exp_match_q.size()) begin
      n_errors++; $display("FAIL random matches got %0d want %0d", mon_match_q.size(), exp_match_q.size());
    end
    if (mon_fd_q.size() != exp_fd_q.size()) begin
      n_errors++; $display("FAIL random frame_done got %0d want %0d", mon_fd_q.size(), exp_fd_q.size());
    end
    if (mon_bad_match != 0) begin n_errors++; $display("FAIL random bad_match got %0d want 0", mon_bad_match); end
    for (int i = 0; i < exp_win_q.size() && i < mon_win_q.size(); i++) begin
      n_checks++;
      if (mon_win_q[i] !== exp_win_q[i]) begin
        n_errors++; $display("FAIL random window[%0d] got %h want %h", i, mon_win_q[i], exp_win_q[i]);
      end
    end
    for (int i = 0; i < exp_match_q.size() && i < mon_match_q.size(); i++) begin
      n_checks++;
      if (mon_match_q[i] != exp_match_q[i]) begin
        n_errors++; $display("FAIL random match_idx[%0d] got %0d want %0d", i, mon_match_q[i], exp_match_q[i]);
      end
    end
    for (int i = 0; i < exp_fd_q.size() && i < mon_fd_q.size(); i++) begin
      n_checks++;
      if (mon_fd_q[i] !== exp_fd_q[i]) begin
        n_errors++; $display("FAIL random fe[%0d] got %b want %b", i, mon_fd_q[i], exp_fd_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_frames();
    test_all_ones();
    test_bad_stop();
    test_glitch();
    test_first_bits();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
